fetch_next_pc: RTL and testbench

- Fetch-stage next-PC datapath: PC register, a 32-bit incrementer (adder32 instance), and a priority chain of 2:1 muxes (mux2_1 instances).
- Each cycle it selects the next fetch address: sequential, BTB prediction, resolved branch target, or mispredict recovery.
- Sits between the branch predictor/BTB outputs, the execute-stage branch resolution and the instruction memory address port.

---
 rtl/fetch_next_pc.sv | 144 ++++++++++++++
 tb/tb_fetch_next_pc.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_next_pc.sv
`default_nettype none
// ============================================================================
// Module   : fetch_next_pc (with helper modules adder32, mux2_1)
// Purpose  : Fetch-stage next-PC datapath. Holds the fetch PC register and
//            picks the next fetch address each cycle from four sources, in
//            priority order (highest first):
//              1. mispredict recovery (predicted taken, resolved not-taken)
//              2. resolved taken branch target from execute
//              3. BTB prediction for the current fetch PC
//              4. sequential PC_F + PC_INCR
// Ports    : CLK, RST_N (async, active low)   clock / reset
//            PC_En                           load enable (low = stall)
//            Predict_Taken_F, PC_Prediction  fetch-stage prediction + target
//            Predict_Taken_E, Branch_Taken_E execute-stage predicted/resolved
//            PC_Target_E, PC_Plus_4_E        execute-stage target/fall-through
//            PC_F                            registered fetch PC
//            PC_Plus_4_F                     PC_F + PC_INCR (combinational)
//            PC_Next                         value loaded at next enabled edge
//            Misaligned_F, Misaligned_Seen   only with FETCH_PC_MISALIGN_EN
// Options  : `define FETCH_PC_MISALIGN_EN to add misalignment outputs.
// Revision : 1.0  initial release
// ============================================================================

// ----------------------------------------------------------------------------
// adder32: modulo-2^XLEN adder, carry out is discarded.
// Ports: a, b operands; out = a + b.
// ----------------------------------------------------------------------------
module adder32 #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] out
);
    assign out = a + b;
endmodule

// ----------------------------------------------------------------------------
// mux2_1: out = sel ? b : a. A conditional operator is used so an unknown
// select propagates X in simulation.
// Ports: a (sel=0), b (sel=1), sel, out.
// ----------------------------------------------------------------------------
module mux2_1 #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            sel,
    output logic [XLEN-1:0] out
);
    assign out = sel ? b : a;
endmodule

// ----------------------------------------------------------------------------
// fetch_next_pc: top level
// ----------------------------------------------------------------------------
module fetch_next_pc #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              PC_INCR  = 4
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            PC_En,
    input  logic            Predict_Taken_F,
    input  logic [XLEN-1:0] PC_Prediction,
    input  logic            Predict_Taken_E,
    input  logic            Branch_Taken_E,
    input  logic [XLEN-1:0] PC_Target_E,
    input  logic [XLEN-1:0] PC_Plus_4_E,
    output logic [XLEN-1:0] PC_F,
    output logic [XLEN-1:0] PC_Plus_4_F,
    output logic [XLEN-1:0] PC_Next
`ifdef FETCH_PC_MISALIGN_EN
    ,
    output logic            Misaligned_F,
    output logic            Misaligned_Seen
`endif
);

    localparam logic [XLEN-1:0] INCR_VEC = XLEN'(PC_INCR);

    logic [XLEN-1:0] pc_predict;
    logic [XLEN-1:0] pc_branch;
    logic            overwrite;

    // Sequential address
    adder32 #(.XLEN(XLEN)) u_incr (
        .a   (PC_F),
        .b   (INCR_VEC),
        .out (PC_Plus_4_F)
    );

    // Lowest-priority choice: BTB prediction over sequential
    mux2_1 #(.XLEN(XLEN)) u_predict_mux (
        .a   (PC_Plus_4_F),
        .b   (PC_Prediction),
        .sel (Predict_Taken_F),
        .out (pc_predict)
    );

    // A resolved taken branch overrides whatever fetch predicted
    mux2_1 #(.XLEN(XLEN)) u_branch_mux (
        .a   (pc_predict),
        .b   (PC_Target_E),
        .sel (Branch_Taken_E),
        .out (pc_branch)
    );

    // Predicted taken but actually fell through: restart at the branch's
    // fall-through address. This outranks everything else.
    assign overwrite = Predict_Taken_E & ~Branch_Taken_E;

    mux2_1 #(.XLEN(XLEN)) u_overwrite_mux (
        .a   (pc_branch),
        .b   (PC_Plus_4_E),
        .sel (overwrite),
        .out (PC_Next)
    );

    // Fetch PC register; PC_En low stalls fetch
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            PC_F <= RESET_PC;
        end else if (PC_En) begin
            PC_F <= PC_Next;
        end
    end

`ifdef FETCH_PC_MISALIGN_EN
    assign Misaligned_F = |PC_F[1:0];

    // Sticky: records that a misaligned address was ever loaded into PC_F
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            Misaligned_Seen <= 1'b0;
        end else if (PC_En && (|PC_Next[1:0])) begin
            Misaligned_Seen <= 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_next_pc.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_next_pc
// Purpose  : Self-checking bench for fetch_next_pc. Directed scenarios with
//            literal expectations, then randomized traffic compared every
//            cycle against a priority-rule reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_next_pc;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        PC_En = 1'b1;
    logic        Predict_Taken_F = 1'b0;
    logic [31:0] PC_Prediction = '0;
    logic        Predict_Taken_E = 1'b0;
    logic        Branch_Taken_E = 1'b0;
    logic [31:0] PC_Target_E = '0;
    logic [31:0] PC_Plus_4_E = '0;
    logic [31:0] PC_F;
    logic [31:0] PC_Plus_4_F;
    logic [31:0] PC_Next;
`ifdef FETCH_PC_MISALIGN_EN
    logic        Misaligned_F;
    logic        Misaligned_Seen;
`endif

    fetch_next_pc #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000),
        .PC_INCR  (4)
    ) dut (
        .CLK             (CLK),
        .RST_N           (RST_N),
        .PC_En           (PC_En),
        .Predict_Taken_F (Predict_Taken_F),
        .PC_Prediction   (PC_Prediction),
        .Predict_Taken_E (Predict_Taken_E),
        .Branch_Taken_E  (Branch_Taken_E),
        .PC_Target_E     (PC_Target_E),
        .PC_Plus_4_E     (PC_Plus_4_E),
        .PC_F            (PC_F),
        .PC_Plus_4_F     (PC_Plus_4_F),
        .PC_Next         (PC_Next)
`ifdef FETCH_PC_MISALIGN_EN
        ,
        .Misaligned_F    (Misaligned_F),
        .Misaligned_Seen (Misaligned_Seen)
`endif
    );

    always #5 CLK = ~CLK;

    int n_pass  = 0;
    int n_total = 0;
    bit cmp_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_next(input logic [31:0] pc);
        if (Predict_Taken_E && !Branch_Taken_E) return PC_Plus_4_E; // mispredict recovery
        if (Branch_Taken_E)                     return PC_Target_E; // resolved taken
        if (Predict_Taken_F)                    return PC_Prediction;
        return pc + 32'd4;
    endfunction

    logic [31:0] m_pc   = 32'h0;
    logic        m_seen = 1'b0;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_pc   = 32'h0;
            m_seen = 1'b0;
        end else if (PC_En) begin
            if (ref_next(m_pc) % 4 != 0) m_seen = 1'b1;
            m_pc = ref_next(m_pc);
        end
    end

    // Per-cycle comparison, away from the active edge
    always @(negedge CLK) begin
        if (cmp_en) begin
            check("pc_f", PC_F, m_pc);
            check("pc_plus_4_f", PC_Plus_4_F, m_pc + 32'd4);
            check("pc_next", PC_Next, ref_next(m_pc));
`ifdef FETCH_PC_MISALIGN_EN
            check("misaligned_f", {31'b0, Misaligned_F}, {31'b0, (m_pc % 4) != 0});
            check("misaligned_seen", {31'b0, Misaligned_Seen}, {31'b0, m_seen});
`endif
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_sel();
        Predict_Taken_F = 1'b0;
        Predict_Taken_E = 1'b0;
        Branch_Taken_E  = 1'b0;
    endtask

    initial begin
        // Reset held with enable high and all selects low
        repeat (3) @(posedge CLK);
        #1;
        check("reset_pc_f", PC_F, 32'h0);
        check("reset_pc_plus_4", PC_Plus_4_F, 32'h4);
        RST_N  = 1'b1;
        cmp_en = 1'b1;
        tick(); check("seq_4", PC_F, 32'h4);
        tick(); check("seq_8", PC_F, 32'h8);

        // Stall at 0x8
        PC_En = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); check("stall_hold", PC_F, 32'h8);
        end
        PC_En = 1'b1;
        tick(); check("seq_c", PC_F, 32'hC);
        tick(); check("seq_10", PC_F, 32'h10);

        // Asynchronous reset between edges
        #1 RST_N = 1'b0;
        #1 check("async_reset", PC_F, 32'h0);
        #1 RST_N = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check("reach_20", PC_F, 32'h20);

        // Prediction
        Predict_Taken_F = 1'b1;
        PC_Prediction   = 32'h100;
        #1 check("predict_next", PC_Next, 32'h100);
        tick(); check("predict_pc", PC_F, 32'h100);

        // Resolved branch beats prediction
        Branch_Taken_E = 1'b1;
        PC_Target_E    = 32'h40;
        tick(); check("branch_over_predict", PC_F, 32'h40);

        // Mispredict recovery beats prediction
        Branch_Taken_E  = 1'b0;
        Predict_Taken_E = 1'b1;
        PC_Plus_4_E     = 32'h24;
        tick(); check("mispredict_recover", PC_F, 32'h24);

        // Wrap-around via branch path
        clear_sel();
        Branch_Taken_E = 1'b1;
        PC_Target_E    = 32'hFFFF_FFFC;
        tick(); check("wrap_load", PC_F, 32'hFFFF_FFFC);
        clear_sel();
        #1 check("wrap_plus4", PC_Plus_4_F, 32'h0);
        tick(); check("wrap_pc", PC_F, 32'h0);

`ifdef FETCH_PC_MISALIGN_EN
        Branch_Taken_E = 1'b1;
        PC_Target_E    = 32'h42;
        tick();
        check("mis_f_set", {31'b0, Misaligned_F}, 32'h1);
        check("mis_seen_set", {31'b0, Misaligned_Seen}, 32'h1);
        PC_Target_E = 32'h80;
        tick();
        check("mis_f_clear", {31'b0, Misaligned_F}, 32'h0);
        check("mis_seen_sticky", {31'b0, Misaligned_Seen}, 32'h1);
        clear_sel();
`endif

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            PC_En           = ($urandom_range(0, 7) != 0);
            Predict_Taken_F = ($urandom_range(0, 2) == 0);
            Predict_Taken_E = ($urandom_range(0, 3) == 0);
            Branch_Taken_E  = ($urandom_range(0, 3) == 0);
            PC_Prediction   = $urandom;
            PC_Target_E     = $urandom;
            PC_Plus_4_E     = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                PC_Prediction[1:0] = 2'b00;
                PC_Target_E[1:0]   = 2'b00;
                PC_Plus_4_E[1:0]   = 2'b00;
            end
            if ($urandom_range(0, 63) == 0) begin
                #1 RST_N = 1'b0;
                #1 check("rand_async_reset", PC_F, 32'h0);
                RST_N = 1'b1;
            end
            tick();
        end

        @(negedge CLK);
        #1 cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
